pot_paddle_model: RTL

- Behavioural responder for the POKEY pot-scan interface: models eight paddle RC networks feeding the scanner's `p[7:0]` comparator inputs.
- Watches the scanner's `dump` / `POTGO` / scan-rate signals, times capacitor "charge" per channel against a programmable target count, and raises `p[i]` when the threshold is crossed.
- Used as the synthesizable paddle stand-in for core-level benches and FPGA builds without analog paddles.

---
 rtl/pot_paddle_model.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pot_paddle_model.sv
// ---------------------------------------------------------------------------
// pot_paddle_model
//
// Synthesizable stand-in for eight analog paddles hanging off the POKEY pot
// scanner. Each channel behaves like an RC network: while the scanner lets
// the capacitors charge, a shared tick counter runs, and a channel's
// comparator output p[i] goes high once the counter passes that channel's
// target. The flag stays high until the next scan start or dump.
//
// Scan modes
//   slow (fastScan=0) : scan starts on the falling edge of dump and counts
//                       keybClk strobes. dump=1 discharges everything.
//   fast (fastScan=1) : scan starts on POTGO and counts every enp cycle.
//                       dump is ignored.
//
// Parameters
//   MAX_COUNT : scan length in ticks; targets >= MAX_COUNT never cross
//   CW        : counter / target width in bits
//
// Ports
//   clk               in   system clock
//   rst_n             in   asynchronous active-low reset
//   enp               in   phase enable; all state advances only when high
//   keybClk           in   slow-scan tick strobe (one enp cycle wide)
//   fastScan          in   1 = fast scan mode, 0 = slow scan mode
//   POTGO             in   fast-mode scan start strobe
//   dump              in   capacitor dump from the scanner (1 = discharged)
//   potMask[7:0]      in   per-channel paddle present; 0 keeps p[i] low
//   target0..target7  in   per-channel crossing count
//   p[7:0]            out  threshold-crossed flags to the scanner
//   busy              out  high while the capacitors are charging
//   done              out  one-enp-cycle pulse when a scan runs to the end
// ---------------------------------------------------------------------------
module pot_paddle_model #(
    parameter int MAX_COUNT = 228,
    parameter int CW        = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enp,
    input  logic          keybClk,
    input  logic          fastScan,
    input  logic          POTGO,
    input  logic          dump,
    input  logic [7:0]    potMask,
    input  logic [CW-1:0] target0,
    input  logic [CW-1:0] target1,
    input  logic [CW-1:0] target2,
    input  logic [CW-1:0] target3,
    input  logic [CW-1:0] target4,
    input  logic [CW-1:0] target5,
    input  logic [CW-1:0] target6,
    input  logic [CW-1:0] target7,
    output logic [7:0]    p,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        ST_DUMPED = 2'd0,
        ST_CHARGE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Counter value on the final tick of a scan.
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_COUNT - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_tgt [8];
    logic [7:0]    r_mask;
    logic [7:0]    r_p;
    logic          r_busy;
    logic          r_done;
    logic          r_dumpQ;

    logic          w_tick;
    logic          w_start;
    logic          w_dumpOvr;
    logic [CW-1:0] w_targets [8];
    logic [7:0]    w_hit;

    // A tick is every enabled cycle in fast mode, or a keybClk strobe in slow.
    assign w_tick    = enp & (fastScan | keybClk);

    // Slow start is the dump falling edge (registered copy high, live low);
    // fast start is the POTGO strobe.
    assign w_start   = enp & ((~fastScan & r_dumpQ & ~dump) | (fastScan & POTGO));

    // Dump discharges all channels in slow mode regardless of state.
    assign w_dumpOvr = enp & ~fastScan & dump;

    always_comb begin
        w_targets[0] = target0;
        w_targets[1] = target1;
        w_targets[2] = target2;
        w_targets[3] = target3;
        w_targets[4] = target4;
        w_targets[5] = target5;
        w_targets[6] = target6;
        w_targets[7] = target7;
    end

    // Channel i crosses on the tick where the pre-increment count equals its
    // target, so target T rises on tick T+1. The count never reaches
    // MAX_COUNT while charging, so larger targets never match.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < 8; i++) begin
            w_hit[i] = r_mask[i] && (r_cnt == r_tgt[i]);
        end
    end

    // Scan FSM. Priority: slow-mode dump, then start (which also wins over a
    // final tick, so a restart never pulses done), then normal charging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_DUMPED;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_p     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dumpQ <= 1'b1;
            for (int i = 0; i < 8; i++) begin
                r_tgt[i] <= '0;
            end
        end else if (enp) begin
            r_dumpQ <= dump;
            r_done  <= 1'b0;
            if (w_dumpOvr) begin
                r_state <= ST_DUMPED;
                r_cnt   <= '0;
                r_p     <= '0;
                r_busy  <= 1'b0;
            end else if (w_start) begin
                r_state <= ST_CHARGE;
                r_cnt   <= '0;
                r_p     <= '0;
                r_busy  <= 1'b1;
                r_mask  <= potMask;
                for (int i = 0; i < 8; i++) begin
                    r_tgt[i] <= w_targets[i];
                end
            end else begin
                case (r_state)
                    ST_CHARGE: begin
                        if (w_tick) begin
                            r_p   <= r_p | w_hit;
                            r_cnt <= r_cnt + CW'(1);
                            if (r_cnt == LAST_CNT) begin
                                r_state <= ST_HOLD;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign p    = r_p;
    assign busy = r_busy;
    assign done = r_done;

endmodule
